// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronised line, mid-bit sampling at CPB clocks per bit,
// optional odd/even parity, 1 or 2 stop bits, framing/break detection with a one-cycle done pulse.
module uart_rx_cfg #(
  parameter int BAUD_RATE       = 115200,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_bit,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CPB   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic [1:0]           settle_reg;
  logic                 armed_reg;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 ones_reg, ones_next;
  logic                 ferr_acc_reg, ferr_acc_next;
  logic                 perr_acc_reg, perr_acc_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 done_reg, done_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 brk_reg, brk_next;
  logic [DATA_BITS-1:0] bit_sel;
  logic                 line;
  logic                 par_mismatch;

  assign line = sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_cnt_reg == 4'(gi));
    end
  endgenerate

  assign par_mismatch = (PARITY == 2) ? (^shift_reg ^ line) : ~(^shift_reg ^ line);

  // A start is only accepted once the line has been seen high after reset (true falling edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= 2'b11;
      settle_reg <= 2'b00;
      armed_reg  <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], data_bit};
      settle_reg <= {settle_reg[0], 1'b1};
      armed_reg  <= armed_reg | (settle_reg[1] & line);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ones_reg     <= 1'b0;
      ferr_acc_reg <= 1'b0;
      perr_acc_reg <= 1'b0;
      data_reg     <= '0;
      done_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      ones_reg     <= ones_next;
      ferr_acc_reg <= ferr_acc_next;
      perr_acc_reg <= perr_acc_next;
      data_reg     <= data_next;
      done_reg     <= done_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      brk_reg      <= brk_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ones_next     = ones_reg;
    ferr_acc_next = ferr_acc_reg;
    perr_acc_next = perr_acc_reg;
    data_next     = data_reg;
    done_next     = 1'b0;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    brk_next      = brk_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next      = '0;
        bit_cnt_next  = '0;
        ones_next     = 1'b0;
        ferr_acc_next = 1'b0;
        perr_acc_next = 1'b0;
        if (armed_reg && !line) state_next = ST_START;
      end
      ST_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == CPB_LAST) begin
          cnt_next   = '0;
          shift_next = (shift_reg & ~bit_sel) | ({DATA_BITS{line}} & bit_sel);
          ones_next  = ones_reg | line;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_reg == CPB_LAST) begin
          cnt_next      = '0;
          ones_next     = ones_reg | line;
          perr_acc_next = par_mismatch;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_reg == CPB_LAST) begin
          cnt_next = '0;
          if (bit_cnt_reg == STOP_LAST) begin
            // Final stop sample: publish the whole frame result at once.
            bit_cnt_next = '0;
            data_next    = shift_reg;
            perr_next    = perr_acc_reg;
            ferr_next    = ferr_acc_reg | ~line;
            brk_next     = ~(ones_reg | line);
            done_next    = 1'b1;
            state_next   = line ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            ferr_acc_next = ferr_acc_reg | ~line;
            ones_next     = ones_reg | line;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_next = '0;
        if (line) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign data       = data_reg;
  assign done       = done_reg;
  assign parity_err = perr_reg;
  assign frame_err  = ferr_reg;
  assign break_det  = brk_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic done0, perr0, ferr0, brk0, busy0;
  logic done1, perr1, ferr1, brk1, busy1;
  logic done2, perr2, ferr2, brk2, busy2;

  uart_rx_cfg #(.BAUD_RATE(100000), .CLOCK_FREQUENCY(1600000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data_bit(rx0), .data(data0), .done(done0),
    .parity_err(perr0), .frame_err(ferr0), .break_det(brk0), .busy(busy0));

  uart_rx_cfg #(.BAUD_RATE(100000), .CLOCK_FREQUENCY(1600000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_bit(rx1), .data(data1), .done(done1),
    .parity_err(perr1), .frame_err(ferr1), .break_det(brk1), .busy(busy1));

  uart_rx_cfg #(.BAUD_RATE(100000), .CLOCK_FREQUENCY(1600000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_bit(rx2), .data(data2), .done(done2),
    .parity_err(perr2), .frame_err(ferr2), .break_det(brk2), .busy(busy2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dcnt0 = 0, dcnt1 = 0, dcnt2 = 0, dcyc0 = 0;
  always @(negedge clk) begin
    if (done0) begin
      dcnt0 <= dcnt0 + 1;
      dcyc0 <= cyc;
    end
    if (done1) dcnt1 <= dcnt1 + 1;
    if (done2) dcnt2 <= dcnt2 + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic v);
    case (ch)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // bits[0] is the start bit; each bit is held for one 16-cycle bit time.
  task automatic send(input int ch, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive(ch, bits[i]);
      wait_cyc(16);
    end
  endtask

  initial begin
    logic [15:0] f;
    int base, start;

    wait_cyc(4);
    chk("rst_data0", 32'(data0), 32'h0);
    chk("rst_done0", 32'(done0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_ferr0", 32'(ferr0), 32'h0);
    chk("rst_brk0", 32'(brk0), 32'h0);
    chk("rst_perr1", 32'(perr1), 32'h0);
    rst_n = 1'b1;
    wait_cyc(10);

    // 8N1 0xA5 with latency check
    base = dcnt0;
    f = {6'b0, 1'b1, 8'hA5, 1'b0};
    start = cyc;
    send(0, f, 10);
    wait_cyc(4);
    $display("frame u0 0xA5: data=%0h done_cnt=%0d", data0, dcnt0 - base);
    chk("a5_done_cnt", 32'(dcnt0 - base), 32'd1);
    chk("a5_data", 32'(data0), 32'hA5);
    chk("a5_perr", 32'(perr0), 32'h0);
    chk("a5_ferr", 32'(ferr0), 32'h0);
    chk("a5_brk", 32'(brk0), 32'h0);
    chk("a5_latency", 32'(dcyc0 - start), 32'd155);
    chk("a5_busy_idle", 32'(busy0), 32'h0);

    // even parity, wrong then right parity bit
    base = dcnt1;
    f = {5'b0, 1'b1, 1'b1, 8'h03, 1'b0};
    send(1, f, 11);
    wait_cyc(4);
    $display("frame u1 0x03 p=1: data=%0h perr=%0b", data1, perr1);
    chk("par_bad_cnt", 32'(dcnt1 - base), 32'd1);
    chk("par_bad_data", 32'(data1), 32'h03);
    chk("par_bad_perr", 32'(perr1), 32'h1);
    chk("par_bad_ferr", 32'(ferr1), 32'h0);
    f = {5'b0, 1'b1, 1'b0, 8'h03, 1'b0};
    send(1, f, 11);
    wait_cyc(4);
    $display("frame u1 0x03 p=0: data=%0h perr=%0b", data1, perr1);
    chk("par_ok_cnt", 32'(dcnt1 - base), 32'd2);
    chk("par_ok_data", 32'(data1), 32'h03);
    chk("par_ok_perr", 32'(perr1), 32'h0);

    // break: line low for 20 bit times
    base = dcnt0;
    rx0 = 1'b0;
    wait_cyc(320);
    $display("break u0: data=%0h ferr=%0b brk=%0b done_cnt=%0d", data0, ferr0, brk0, dcnt0 - base);
    chk("brk_cnt", 32'(dcnt0 - base), 32'd1);
    chk("brk_data", 32'(data0), 32'h0);
    chk("brk_ferr", 32'(ferr0), 32'h1);
    chk("brk_brk", 32'(brk0), 32'h1);
    chk("brk_wait_busy", 32'(busy0), 32'h1);
    rx0 = 1'b1;
    wait_cyc(20);
    chk("brk_release_busy", 32'(busy0), 32'h0);
    chk("brk_release_cnt", 32'(dcnt0 - base), 32'd1);
    f = {6'b0, 1'b1, 8'h3C, 1'b0};
    send(0, f, 10);
    wait_cyc(4);
    $display("frame u0 0x3C: data=%0h ferr=%0b brk=%0b", data0, ferr0, brk0);
    chk("post_brk_cnt", 32'(dcnt0 - base), 32'd2);
    chk("post_brk_data", 32'(data0), 32'h3C);
    chk("post_brk_ferr", 32'(ferr0), 32'h0);
    chk("post_brk_brk", 32'(brk0), 32'h0);

    // 4-cycle glitch is rejected
    base = dcnt0;
    rx0 = 1'b0;
    wait_cyc(4);
    rx0 = 1'b1;
    chk("glitch_busy_hi", 32'(busy0), 32'h1);
    wait_cyc(11);
    chk("glitch_busy_lo", 32'(busy0), 32'h0);
    wait_cyc(200);
    $display("glitch u0: done_cnt=%0d data=%0h", dcnt0 - base, data0);
    chk("glitch_no_done", 32'(dcnt0 - base), 32'd0);
    chk("glitch_hold_data", 32'(data0), 32'h3C);

    // 7N2, second stop bit low
    base = dcnt2;
    f = {6'b0, 1'b0, 1'b1, 7'h55, 1'b0};
    send(2, f, 10);
    rx2 = 1'b1;
    wait_cyc(20);
    $display("frame u2 0x55 stop2=0: data=%0h ferr=%0b", data2, ferr2);
    chk("stop2_cnt", 32'(dcnt2 - base), 32'd1);
    chk("stop2_data", 32'(data2), 32'h55);
    chk("stop2_ferr", 32'(ferr2), 32'h1);
    chk("stop2_brk", 32'(brk2), 32'h0);
    f = {6'b0, 2'b11, 7'h2A, 1'b0};
    send(2, f, 10);
    $display("frame u2 0x2A: data=%0h ferr=%0b", data2, ferr2);
    chk("b2b1_cnt", 32'(dcnt2 - base), 32'd2);
    chk("b2b1_data", 32'(data2), 32'h2A);
    chk("b2b1_ferr", 32'(ferr2), 32'h0);
    f = {6'b0, 2'b11, 7'h13, 1'b0};
    send(2, f, 10);
    wait_cyc(4);
    $display("frame u2 0x13: data=%0h ferr=%0b", data2, ferr2);
    chk("b2b2_cnt", 32'(dcnt2 - base), 32'd3);
    chk("b2b2_data", 32'(data2), 32'h13);
    chk("b2b2_ferr", 32'(ferr2), 32'h0);

    // reset during data bit 4
    base = dcnt0;
    f = {6'b0, 1'b1, 8'h5A, 1'b0};
    send(0, f, 5);
    drive(0, f[5]);
    wait_cyc(8);
    rst_n = 1'b0;
    wait_cyc(1);
    $display("reset mid-frame u0: data=%0h busy=%0b", data0, busy0);
    chk("midrst_data0", 32'(data0), 32'h0);
    chk("midrst_busy0", 32'(busy0), 32'h0);
    chk("midrst_ferr0", 32'(ferr0), 32'h0);
    chk("midrst_data2", 32'(data2), 32'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    rx0 = 1'b1;
    wait_cyc(30);
    chk("midrst_no_done", 32'(dcnt0 - base), 32'd0);
    f = {6'b0, 1'b1, 8'h96, 1'b0};
    send(0, f, 10);
    wait_cyc(4);
    $display("frame u0 0x96: data=%0h ferr=%0b", data0, ferr0);
    chk("after_rst_cnt", 32'(dcnt0 - base), 32'd1);
    chk("after_rst_data", 32'(data0), 32'h96);
    chk("after_rst_ferr", 32'(ferr0), 32'h0);
    chk("after_rst_brk", 32'(brk0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
